// File: rtl/apb3_completer_regfile.sv
// apb3_completer_regfile: APB3 completer backed by a word-addressed register
// file. Every ACCESS phase is stretched by WaitStates PREADY-low cycles, and
// misaligned or out-of-range transfers complete with PSLVERR and leave the
// registers untouched.
// Build option: define APB3_COMPLETER_REGFILE_PROTOCOL_CHECK_EN to add an
// 8-bit saturating protocol-violation counter. It is read-only at index
// RegCount.
module apb3_completer_regfile #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int RegCount     = 8,
  parameter int WaitStates   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [AddressWidth-1:0] paddr,
  input  logic [DataWidth-1:0]    pwdata,
  output logic [DataWidth-1:0]    prdata,
  output logic                    pready,
  output logic                    pslverr
);
  localparam int OffW    = $clog2(DataWidth / 8);
  localparam int RegIdxW = (RegCount > 1) ? $clog2(RegCount) : 1;
  localparam logic [AddressWidth-1:0] OffMask   = AddressWidth'((1 << OffW) - 1);
  localparam logic [AddressWidth-1:0] RegCountA = AddressWidth'(RegCount);
  localparam logic [3:0]              WaitInit  = 4'(WaitStates);

  // The bus setup phase is not held in a register. It is the cycle in which
  // psel=1 and penable=0 arrive while the block is idle or completing. The
  // edge that closes that cycle (the "setup edge") moves the block to ACCESS.
  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DataWidth-1:0]  prdata_q, prdata_d;
  logic [RegIdxW-1:0]    idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  legal_q, legal_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic [DataWidth-1:0]  regs_q [RegCount];

  logic [AddressWidth-1:0] word_addr;
  logic                    aligned, in_range, legal;
  logic [DataWidth-1:0]    rd_val;
  logic                    setup, complete, abort, commit;

`ifdef APB3_COMPLETER_REGFILE_PROTOCOL_CHECK_EN
  logic [AddressWidth-1:0] paddr_q, paddr_d;
  logic [7:0]              viol_q, viol_d;
  logic                    viol_evt;
`endif

  // Classify the address on the bus and fetch the read value it selects.
  always_comb begin
    word_addr = paddr >> OffW;
    aligned   = (paddr & OffMask) == '0;
    in_range  = word_addr < RegCountA;
    legal     = aligned && in_range;
    rd_val    = regs_q[word_addr[RegIdxW-1:0]];
`ifdef APB3_COMPLETER_REGFILE_PROTOCOL_CHECK_EN
    if (aligned && (word_addr == RegCountA)) begin
      legal  = !pwrite;
      rd_val = DataWidth'(viol_q);
    end
`endif
  end

  assign setup    = psel && !penable && ((state_q == ST_IDLE) || pready_q);
  assign complete = (state_q == ST_ACCESS) && pready_q;
  assign abort    = (state_q == ST_ACCESS) && !pready_q && !psel;
  assign commit   = complete && write_q && legal_q;

  // Next-state logic: latch on the setup edge, count waits, finish or abort.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    idx_d     = idx_q;
    write_d   = write_q;
    legal_d   = legal_q;
    wdata_d   = wdata_q;
    if (setup) begin
      state_d   = ST_ACCESS;
      cnt_d     = WaitInit;
      pready_d  = (WaitInit == 4'd0);
      pslverr_d = (WaitInit == 4'd0) && !legal;
      prdata_d  = legal ? rd_val : '0;
      idx_d     = word_addr[RegIdxW-1:0];
      write_d   = pwrite;
      legal_d   = legal;
      wdata_d   = pwdata;
    end else if (complete || abort) begin
      state_d   = ST_IDLE;
      cnt_d     = 4'd0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
    end else if ((state_q == ST_ACCESS) && (cnt_q != 4'd0)) begin
      cnt_d     = cnt_q - 4'd1;
      pready_d  = (cnt_q == 4'd1);
      pslverr_d = (cnt_q == 4'd1) && !legal_q;
    end
  end

  // Control and latched-transfer state; reset returns straight to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      legal_q   <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      legal_q   <= legal_d;
      wdata_q   <= wdata_d;
    end
  end

  // Register file: cleared by reset and written only by a legal, completing write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RegCount; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[idx_q] <= wdata_q;
    end
  end

`ifdef APB3_COMPLETER_REGFILE_PROTOCOL_CHECK_EN
  // Count cycles where the requester disturbs a stalled transfer or raises penable while idle.
  always_comb begin
    viol_evt = 1'b0;
    if ((state_q == ST_ACCESS) && !pready_q &&
        ((paddr != paddr_q) || (pwrite != write_q) || (pwdata != wdata_q)))
      viol_evt = 1'b1;
    if ((state_q == ST_IDLE) && penable)
      viol_evt = 1'b1;
    viol_d  = (viol_evt && (viol_q != 8'hFF)) ? viol_q + 8'd1 : viol_q;
    paddr_d = setup ? paddr : paddr_q;
  end

  // Violation counter and the address it compares against.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_q  <= 8'd0;
      paddr_q <= '0;
    end else begin
      viol_q  <= viol_d;
      paddr_q <= paddr_d;
    end
  end
`endif

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: doc/apb3_completer_regfile.md
# apb3_completer_regfile

Synthesizable APB3 completer holding a word-addressed register file with programmable wait states and error signalling. It sits directly downstream of the synthesizable APB3 requester and consumes its transfers in place of the Renode-side completer. This lets requester traffic patterns be exercised and checked entirely in RTL, and the block doubles as a DUT-side memory target for co-simulation benches.

## Interface
- AddressWidth, 32: PADDR width.
- DataWidth, 32: PWDATA/PRDATA width; must be 8, 16 or 32.
- RegCount, 8: number of registers, 1..256.
- WaitStates, 0: PREADY-low cycles inserted in every ACCESS phase, 0..15.
- clk  in  1  bus clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- psel  in  1  APB3 PSEL.
- penable  in  1  APB3 PENABLE.
- pwrite  in  1  APB3 PWRITE.
- paddr  in  AddressWidth  APB3 PADDR, byte address.
- pwdata  in  DataWidth  APB3 PWDATA.
- prdata  out  DataWidth  APB3 PRDATA.
- pready  out  1  APB3 PREADY.
- pslverr  out  1  APB3 PSLVERR.

## Operation
- Word size is DataWidth/8 bytes. Index = paddr / word size.
- A transfer is legal when the low log2(word size) bits of paddr are 0 and the index is below RegCount. Any other transfer is an error.
- FSM states:
  - IDLE to SETUP when psel=1 and penable=0.
  - SETUP to ACCESS unconditionally.
  - ACCESS stays in ACCESS while pready=0.
  - ACCESS to IDLE when pready=1 and psel=0 at that edge.
  - ACCESS to SETUP when pready=1 and psel=1, penable=0 at that edge (back-to-back).
- On the SETUP edge the block latches index, pwrite, the legality result and pwdata. The wait counter is loaded with WaitStates.
- In ACCESS, the wait counter decrements each cycle until it reaches 0. pready = (state==ACCESS && counter==0).
- Write commit happens at the ACCESS edge where pready=1 and the transfer is legal. Latched pwdata goes to the register. An illegal write leaves all registers unchanged.
- Read: prdata is registered at the SETUP edge from regfile[index], or 0 if the transfer is illegal. It holds through ACCESS and holds its last value otherwise.
- pslverr = pready && latched-illegal. It is 0 outside the completing cycle.
- penable=1 seen in IDLE (no SETUP) is ignored: no pready, no state change.
- psel dropping during ACCESS before completion aborts the transfer. FSM returns to IDLE and no write commits.

## Timing
- Reset values: all registers 0, prdata 0, pready 0, pslverr 0, FSM IDLE, wait counter 0.
- A reset assertion mid-transfer returns the FSM to IDLE immediately (asynchronous) and discards any pending write.
- With WaitStates=0 a transfer takes 2 cycles (SETUP, ACCESS) with pready=1 in the first ACCESS cycle. With WaitStates=N it takes 2+N cycles.
- Back-to-back transfers add no idle cycle. The next SETUP may coincide with the cycle after completion.
- A read that follows a write to the same register returns the new value, because the write commits one edge before the read's SETUP edge at the earliest.

## Configuration
- APB3_COMPLETER_REGFILE_PROTOCOL_CHECK_EN:
  - Defined: an 8-bit saturating violation counter is added. It increments once per cycle in ACCESS with pready=0 when paddr, pwrite or pwdata differs from the SETUP-latched value, and once for penable=1 in IDLE. The counter is readable, zero-extended, at index RegCount; writes there are errors. It resets to 0.
  - Undefined: no counter is built, and index RegCount is illegal like any other out-of-range index.

## Test plan
- Reset then read all RegCount indices, WaitStates=0 -> prdata=0, pslverr=0, each transfer 2 cycles.
- Write 0xA5A5_0001+i to index i, back-to-back, then read back -> exact values, no idle cycles between transfers.
- WaitStates=3: write 0x1234_5678 to 0x4, read 0x4 -> pready low 3 ACCESS cycles, then high; read returns 0x1234_5678.
- Write to 0x2 (misaligned) and to RegCount*4 (out of range, macro undefined) -> pslverr=1 on completion, prdata=0, register contents unchanged.
- Assert rst_n low during ACCESS of a write of 0xDEAD_BEEF -> pready/pslverr drop immediately, register reads back 0.
- Macro defined, WaitStates=2: change paddr mid-ACCESS for 2 cycles -> read of index RegCount returns 2; 300 violations -> saturates at 255.
